// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame
// parameters and the parity helper used when a byte is latched.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam int DATA_BITS      = 8;
  localparam bit DEF_PARITY_EN  = 1'b0;
  localparam bit DEF_PARITY_ODD = 1'b0;
  localparam int DEF_STOP_BITS  = 1;

  // Parity bit for a byte: even parity makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte from a valid/ready source and shifts out
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits on baud_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter bit PARITY_EN  = DEF_PARITY_EN,
  parameter bit PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [0:0] STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t  state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic       parity_reg, parity_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [0:0] stop_cnt_reg, stop_cnt_next;
  logic       serial_reg, serial_next;
  logic       done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= '0;
      serial_reg   <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      serial_reg   <= serial_next;
      done_reg     <= done_next;
    end
  end

  // The line value is computed for the state being entered, so the pin
  // only moves on the edge that consumes a baud_tick.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    serial_next   = serial_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        serial_next = 1'b1;
        if (tx_valid) begin
          state_next  = SYNC;
          shift_next  = tx_data;
          parity_next = byte_parity(tx_data, PARITY_ODD);
        end
      end
      SYNC: begin
        if (baud_tick) begin
          state_next    = START;
          bit_cnt_next  = '0;
          stop_cnt_next = '0;
          serial_next   = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next  = DATA;
          serial_next = shift_reg[0];
          shift_next  = shift_reg >> 1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_reg == BIT_LAST) begin
            if (PARITY_EN) begin
              state_next  = PARITY;
              serial_next = parity_reg;
            end else begin
              state_next  = STOP;
              serial_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            serial_next  = shift_reg[0];
            shift_next   = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_next  = STOP;
          serial_next = 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
      end
    endcase
  end

  assign tx_ready  = (state_reg == IDLE);
  assign tx_busy   = (state_reg != IDLE);
  assign tx_serial = serial_reg;
  assign tx_done   = done_reg;

endmodule
